sccb_target: RTL and testbench
==============================

# sccb_target

SCCB/I2C-compatible target (slave) that answers the camera-control bus from the target side. It decodes START/STOP, device address, 16-bit register address and data bytes, and presents them on a simple register port. It lets the PS-side SCCB master be verified in loopback, or exposes PL control registers over the same two-wire bus, without a physical OV5647 attached. It sits behind the same open-drain pad logic as the camera bus: SDA is pulled low when `sccb_data_en` is 1, and SCL is input only.

## Interface
Parameters:
- `DEV_ADDR`, 7'h36: 7-bit device address. Write byte 0x6C, read byte 0x6D.

Ports:
- `sys_clock`, in, 1: single clock for all logic, ≥ 8× SCL frequency.
- `reset`, in, 1: asynchronous, active-high. Clears every flop.
- `sccb_clk_in`, in, 1: raw SCL from the pad.
- `sccb_data_in`, in, 1: raw SDA from the pad.
- `sccb_data_en`, out, 1: 1 = pull SDA low, 0 = release SDA.
- `reg_addr`, out, 16: current register pointer.
- `reg_wdata`, out, 8: write data, valid while `reg_we` = 1.
- `reg_we`, out, 1: one-cycle write strobe.
- `reg_re`, out, 1: one-cycle read strobe. `reg_rdata` is sampled on the next cycle.
- `reg_rdata`, in, 8: read data supplied by the register owner.
- `busy`, out, 1: 1 from START until STOP.

## Operation
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer, then a third flop for edge detection.
  - All bus events below are detected on the synchronized signals.
- START: SDA falls while SCL = 1. Also valid mid-transfer as a repeated START; it always moves to DEV.
- STOP: SDA rises while SCL = 1. From any state it goes to IDLE, releases SDA and sets `busy` = 0.
- Data is sampled on the SCL rising edge, MSB first. Bit count is 3 bits plus an ACK phase.
- State machine:
  - IDLE: wait for START.
  - DEV: shift 8 bits.
    - Address matches `DEV_ADDR`: go to ACK_DEV.
    - Address does not match: go to IGNORE (no ACK, no strobes).
  - ACK_DEV: drive ACK.
    - R/W = 0: go to AHI.
    - R/W = 1: pulse `reg_re`, go to RD.
  - AHI, ACK_AHI: load `reg_addr[15:8]`, drive ACK.
  - ALO, ACK_ALO: load `reg_addr[7:0]`, drive ACK.
  - WR: shift 8 bits, then pulse `reg_we` with `reg_wdata`, drive ACK, go to ACK_WR.
  - ACK_WR: return to WR and increment `reg_addr` by 1 after the write strobe.
  - RD: drive the 8 bits of the captured byte.
  - MACK: sample the master's ACK bit.
    - SDA = 0 (ACK): increment `reg_addr`, pulse `reg_re`, go to RD.
    - SDA = 1 (NACK): go to IGNORE.
  - IGNORE: release SDA, wait for START or STOP.
- Pointer rules:
  - `reg_addr` wraps from 0xFFFF to 0x0000.
  - The pointer persists across transactions.
  - A read with no preceding address phase uses the current pointer. This is how a write-pointer, repeated-START, read sequence works.

## Timing
- Reset values: `sccb_data_en` = 0, `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_re` = 0, `busy` = 0, state = IDLE.
- Detection latency is 3 `sys_clock` cycles from a pad edge.
- `sccb_data_en` changes only on the cycle after a detected SCL falling edge. SDA is therefore stable while SCL is high.
- ACK: `sccb_data_en` = 1 from the falling edge after bit 8 until the falling edge after bit 9.
- Write strobe: `reg_we` pulses on the cycle after the 8th SCL rising edge of a data byte.
  - `reg_wdata` is valid in the same cycle.
  - `reg_addr` increments on the following cycle.
- Read strobe: `reg_re` pulses on the cycle after the 9th SCL rising edge (ACK or MACK).
  - `reg_rdata` is captured 1 cycle later.
  - The captured MSB is driven at the next SCL falling edge.
- During RD, `sccb_data_en` = ~bit. A 1 bit releases SDA.
- STOP/START inside a byte:
  - Abort the byte with no strobe.
  - Release SDA on the detection cycle.
- If START and an SCL edge are detected in the same cycle, START wins.
- Asserting `reset` mid-byte releases SDA immediately, asynchronously.

## Test plan
- Single write: START, 0x6C, 0x01, 0x00, 0xA5, STOP.
  - 4 ACKs observed.
  - `reg_we` pulses once with `reg_addr` = 0x0100 and `reg_wdata` = 0xA5.
  - `busy` drops after STOP.
- Burst write: 0x6C, 0xFF, 0xFF, 0x11, 0x22.
  - Strobes at 0xFFFF/0x11 and 0x0000/0x22, showing wrap.
- Pointer-then-read: 0x6C, 0x30, 0x0A, repeated START, 0x6D, with `reg_rdata` = 0x56, then master ACK, then master NACK.
  - SDA carries 0x56, then the byte at 0x300B.
  - `reg_re` pulses 2 times.
  - SDA is released after the NACK.
- Wrong address: 0x78.
  - SDA is never pulled low, no strobes, IGNORE until STOP.
- STOP after 4 data bits of a write byte: no `reg_we`, state = IDLE, `sccb_data_en` = 0.
- `reset` asserted during the ACK phase: `sccb_data_en` = 0 asynchronously and all outputs return to reset values. The next START/0x6C is accepted normally.

Source files
------------

// File: rtl/sccb_target.sv
// SCCB/I2C-compatible bus target: decodes device address, 16-bit register pointer and data
// bytes from the two-wire bus and presents them on a simple strobed register port.
module sccb_target #(
  parameter logic [6:0] DEV_ADDR = 7'h36
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        sccb_clk_in,
  input  logic        sccb_data_in,
  output logic        sccb_data_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WR, ACK_WR, RD, MACK, IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  tx, tx_nxt;
  logic        rw, rw_nxt;
  logic        rd_cap;
  logic        sda_en_nxt, busy_nxt, we_nxt, re_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  wdata_nxt;
  logic        scl_rise, scl_fall, start_det, stop_det, byte_last, shifting;
  logic [7:0]  byte_in;

  // Stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detection
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      scl_p0 <= 1'b0; scl_p1 <= 1'b0; scl_p2 <= 1'b0;
      sda_p0 <= 1'b0; sda_p1 <= 1'b0; sda_p2 <= 1'b0;
    end else begin
      scl_p0 <= sccb_clk_in;  scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sccb_data_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
  assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
  assign byte_in   = {shreg[6:0], sda_p1};
  assign byte_last = scl_rise && (bit_cnt == 3'd7);
  assign shifting  = (state == DEV) || (state == AHI) || (state == ALO) ||
                     (state == WR)  || (state == RD);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    rw_nxt      = rw;
    sda_en_nxt  = sccb_data_en;
    busy_nxt    = busy;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wdata;

    // Pointer advances the cycle after a write strobe; read data lands one cycle after reg_re
    if (reg_we) addr_nxt = reg_addr + 16'd1;
    if (rd_cap) tx_nxt = reg_rdata;

    if (start_det) begin
      state_nxt   = DEV;
      bit_cnt_nxt = 3'd0;
      sda_en_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      sda_en_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      if (scl_rise && shifting) begin
        shreg_nxt   = byte_in;
        bit_cnt_nxt = bit_cnt + 3'd1;
      end
      case (state)
        IDLE, IGNORE: sda_en_nxt = 1'b0;
        DEV: begin
          if (scl_fall) sda_en_nxt = 1'b0;
          if (byte_last) begin
            rw_nxt    = byte_in[0];
            state_nxt = (byte_in[7:1] == DEV_ADDR) ? ACK_DEV : IGNORE;
          end
        end
        ACK_DEV: begin
          if (scl_fall) sda_en_nxt = 1'b1;
          if (scl_rise) begin
            re_nxt    = rw;
            state_nxt = rw ? RD : AHI;
          end
        end
        AHI: begin
          if (scl_fall) sda_en_nxt = 1'b0;
          if (byte_last) begin
            addr_nxt[15:8] = byte_in;
            state_nxt      = ACK_AHI;
          end
        end
        ACK_AHI: begin
          if (scl_fall) sda_en_nxt = 1'b1;
          if (scl_rise) state_nxt = ALO;
        end
        ALO: begin
          if (scl_fall) sda_en_nxt = 1'b0;
          if (byte_last) begin
            addr_nxt[7:0] = byte_in;
            state_nxt     = ACK_ALO;
          end
        end
        ACK_ALO: begin
          if (scl_fall) sda_en_nxt = 1'b1;
          if (scl_rise) state_nxt = WR;
        end
        WR: begin
          if (scl_fall) sda_en_nxt = 1'b0;
          if (byte_last) begin
            we_nxt    = 1'b1;
            wdata_nxt = byte_in;
            state_nxt = ACK_WR;
          end
        end
        ACK_WR: begin
          if (scl_fall) sda_en_nxt = 1'b1;
          if (scl_rise) state_nxt = WR;
        end
        RD: begin
          // Pull low for a 0 bit, release for a 1 bit
          if (scl_fall) begin
            sda_en_nxt = ~tx[7];
            tx_nxt     = {tx[6:0], 1'b1};
          end
          if (byte_last) state_nxt = MACK;
        end
        MACK: begin
          if (scl_fall) sda_en_nxt = 1'b0;
          if (scl_rise) begin
            if (!sda_p1) begin
              addr_nxt  = reg_addr + 16'd1;
              re_nxt    = 1'b1;
              state_nxt = RD;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      tx           <= 8'd0;
      rw           <= 1'b0;
      rd_cap       <= 1'b0;
      sccb_data_en <= 1'b0;
      busy         <= 1'b0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      reg_addr     <= 16'd0;
      reg_wdata    <= 8'd0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= shreg_nxt;
      tx           <= tx_nxt;
      rw           <= rw_nxt;
      rd_cap       <= reg_re;
      sccb_data_en <= sda_en_nxt;
      busy         <= busy_nxt;
      reg_we       <= we_nxt;
      reg_re       <= re_nxt;
      reg_addr     <= addr_nxt;
      reg_wdata    <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged bus master over an open-drain SDA model.
module tb_sccb_target;

  localparam int Q = 8;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sccb_data_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we, reg_re, busy;
  logic [7:0]  reg_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  logic [23:0] we_q[$];
  int          re_n = 0;
  int          en_n = 0;

  assign sda_bus = sda_m & ~sccb_data_en;

  sccb_target #(.DEV_ADDR(7'h36)) dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .sccb_clk_in  (scl_m),
    .sccb_data_in (sda_bus),
    .sccb_data_en (sccb_data_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .busy         (busy)
  );

  always #5 sys_clock = ~sys_clock;

  always_comb begin
    case (reg_addr)
      16'h300A: reg_rdata = 8'h56;
      16'h300B: reg_rdata = 8'hC3;
      default:  reg_rdata = 8'h00;
    endcase
  end

  always @(negedge sys_clock) begin
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_n++;
    if (sccb_data_en) en_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      d = {d[6:0], sda_bus};
      tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    send_bit(~mack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    logic       ack;
    int         acks, base, re0, en0;
    logic [7:0] d;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    chk("rst_sda_en", sccb_data_en, 1'b0);
    chk("rst_addr",   reg_addr,     16'h0000);
    chk("rst_wdata",  reg_wdata,    8'h00);
    chk("rst_we",     reg_we,       1'b0);
    chk("rst_re",     reg_re,       1'b0);
    chk("rst_busy",   busy,         1'b0);
    reset = 1'b0;
    tick(4);

    // single write
    base = we_q.size(); acks = 0;
    bus_start();
    chk("wr1_busy", busy, 1'b1);
    send_byte(8'h6C, ack); acks += int'(ack);
    send_byte(8'h01, ack); acks += int'(ack);
    send_byte(8'h00, ack); acks += int'(ack);
    send_byte(8'hA5, ack); acks += int'(ack);
    bus_stop();
    tick(4);
    chk("wr1_acks",  acks, 4);
    chk("wr1_we_n",  we_q.size() - base, 1);
    if (we_q.size() > base) chk("wr1_we0", we_q[base], 24'h0100A5);
    chk("wr1_addr",  reg_addr, 16'h0101);
    chk("wr1_busy0", busy, 1'b0);

    // burst write across the pointer wrap
    base = we_q.size();
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    chk("bw_ack_last", ack, 1'b1);
    bus_stop();
    tick(4);
    chk("bw_we_n", we_q.size() - base, 2);
    if (we_q.size() > base + 1) begin
      chk("bw_we0", we_q[base],     24'hFFFF11);
      chk("bw_we1", we_q[base + 1], 24'h000022);
    end
    chk("bw_addr", reg_addr, 16'h0001);

    // pointer set, repeated START, two-byte read
    re0 = re_n;
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'h30, ack);
    send_byte(8'h0A, ack);
    chk("rd_ptr_ack", ack, 1'b1);
    bus_start();
    send_byte(8'h6D, ack);
    chk("rd_dev_ack", ack, 1'b1);
    recv_byte(1'b1, d);
    chk("rd_byte0", d, 8'h56);
    recv_byte(1'b0, d);
    chk("rd_byte1", d, 8'hC3);
    tick(2);
    chk("rd_released", sccb_data_en, 1'b0);
    chk("rd_re_n",     re_n - re0, 2);
    chk("rd_addr",     reg_addr, 16'h300B);
    bus_stop();
    tick(4);

    // wrong device address
    base = we_q.size(); re0 = re_n; en0 = en_n;
    bus_start();
    send_byte(8'h78, ack);
    chk("wa_ack", ack, 1'b0);
    send_byte(8'h00, ack);
    chk("wa_ack2", ack, 1'b0);
    chk("wa_busy", busy, 1'b1);
    bus_stop();
    tick(4);
    chk("wa_en_cycles", en_n - en0, 0);
    chk("wa_we_n", we_q.size() - base, 0);
    chk("wa_re_n", re_n - re0, 0);
    chk("wa_busy0", busy, 1'b0);

    // STOP after four data bits of a write byte
    base = we_q.size();
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'h00, ack);
    send_byte(8'h10, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    tick(4);
    chk("ab_we_n",   we_q.size() - base, 0);
    chk("ab_busy",   busy, 1'b0);
    chk("ab_sda_en", sccb_data_en, 1'b0);
    chk("ab_addr",   reg_addr, 16'h0010);

    // reset asserted while the device-address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'((8'h6C >> i) & 8'h01));
    sda_m = 1'b1;
    chk("rs_ack_driven", sccb_data_en, 1'b1);
    #3 reset = 1'b1;
    #1 chk("rs_async_release", sccb_data_en, 1'b0);
    tick(2);
    chk("rs_addr", reg_addr, 16'h0000);
    chk("rs_busy", busy, 1'b0);
    chk("rs_we",   reg_we, 1'b0);
    reset = 1'b0;
    tick(4);
    bus_start();
    send_byte(8'h6C, ack);
    chk("rs_next_ack", ack, 1'b1);
    chk("rs_next_busy", busy, 1'b1);
    bus_stop();
    tick(4);
    chk("rs_next_busy0", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
